sw_replay: RTL and testbench

SW_REPLAY -- requirements
Module: sw_replay

---
 rtl/sw_replay_pkg.sv | 9 +
 rtl/dec_hex.sv | 26 ++
 rtl/sw_replay.sv | 96 +++++++++
 tb/tb_sw_replay.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sw_replay_pkg.sv
// Shared constants for the switch-word replay buffer: FSM encoding and defaults.
package sw_replay_pkg;
  localparam int SW_W       = 10;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_PERIOD = 100_000_000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;
endpackage

// File: rtl/dec_hex.sv
// Hex digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module dec_hex (
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);
  always_comb begin
    unique case (val_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/sw_replay.sv
// Circular buffer of switch words with manual pop and timed automatic playback.
module sw_replay
  import sw_replay_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            wr_click_i,
  input  logic            rd_click_i,
  input  logic            play_click_i,
  output logic [SW_W-1:0] ledr_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovf_o,
  output logic            playing_o,
  output logic [6:0]      hex0_o,
  output logic [6:0]      hex1_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] RELOAD  = TW'(PERIOD - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [SW_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [0:0]      state_q, state_d;
  logic [SW_W-1:0] ledr_q;
  logic            ovf_q;
  logic            pop, push, empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    if (state_q == ST_IDLE) pop = rd_click_i && !empty;
    else                    pop = !play_click_i && (timer_q == '0) && !empty;
    // A pop on the same edge frees the slot, so a write to a full buffer still lands.
    push    = wr_click_i && (!full || pop);
    count_d = count_q + CW'(push) - CW'(pop);
    state_d = state_q;
    timer_d = timer_q;
    if (state_q == ST_IDLE) begin
      if (play_click_i && !empty && (count_d != '0)) begin
        state_d = ST_PLAY;
        timer_d = RELOAD;
      end
    end else if (play_click_i) begin
      state_d = ST_IDLE;
    end else begin
      timer_d = (timer_q == '0) ? RELOAD : timer_q - TW'(1);
      if (pop && (count_d == '0)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      state_q  <= ST_IDLE;
      ledr_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      timer_q <= timer_d;
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        ledr_q   <= mem_q[rd_ptr_q];
      end
      if (wr_click_i && !push) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset; only the pointers give it meaning.
  always_ff @(posedge clk100_i) begin
    if (push) mem_q[wr_ptr_q] <= sw_i;
  end

  assign ledr_o    = ledr_q;
  assign full_o    = full;
  assign empty_o   = empty;
  assign ovf_o     = ovf_q;
  assign playing_o = (state_q == ST_PLAY);

  dec_hex u_hex0 (.val_i(4'(count_q)),  .seg_o(hex0_o));
  dec_hex u_hex1 (.val_i(4'(rd_ptr_q)), .seg_o(hex1_o));
endmodule

// File: tb/tb_sw_replay.sv
// Scoreboard bench for sw_replay: queue-based reference model, monitor compares each cycle.
module tb_sw_replay;
  localparam int DEPTH  = 8;
  localparam int PERIOD = 4;

  typedef struct packed {
    logic [9:0] ledr;
    logic       full, empty, ovf, playing;
    logic [6:0] hex0, hex1;
  } obs_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic [9:0] sw = '0;
  logic       wr = 1'b0, rd = 1'b0, pl = 1'b0;
  logic [9:0] ledr;
  logic       full, empty, ovf, playing;
  logic [6:0] hex0, hex1;

  sw_replay #(.DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
    .clk100_i(clk), .rst_i(rst), .sw_i(sw), .wr_click_i(wr), .rd_click_i(rd),
    .play_click_i(pl), .ledr_o(ledr), .full_o(full), .empty_o(empty), .ovf_o(ovf),
    .playing_o(playing), .hex0_o(hex0), .hex1_o(hex1)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  obs_t exp_q[$];

  // Reference model: plain queue of stored words plus a playback countdown.
  logic [9:0] mq[$];
  logic [9:0] m_led;
  bit         m_ovf, m_play;
  int         m_tmr, m_pops;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h7f;
    endcase
  endfunction

  function automatic void model_reset();
    mq.delete(); m_led = '0; m_ovf = 0; m_play = 0; m_tmr = 0; m_pops = 0;
  endfunction

  function automatic void model_step(input bit w, input bit r, input bit p, input logic [9:0] d);
    int  n = mq.size();
    bit  take = 0, keep;
    if (!m_play) take = r && (n > 0);
    else         take = !p && (m_tmr == 0);
    keep = w && ((n < DEPTH) || take);
    if (w && !keep) m_ovf = 1;
    if (take) begin m_led = mq.pop_front(); m_pops++; end
    if (keep) mq.push_back(d);
    if (!m_play) begin
      if (p && (n > 0) && (mq.size() > 0)) begin m_play = 1; m_tmr = PERIOD - 1; end
    end else if (p) m_play = 0;
    else begin
      m_tmr = (m_tmr == 0) ? PERIOD - 1 : m_tmr - 1;
      if (take && mq.size() == 0) m_play = 0;
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.ledr = m_led; o.full = (mq.size() == DEPTH); o.empty = (mq.size() == 0);
    o.ovf = m_ovf; o.playing = m_play;
    o.hex0 = seg(mq.size()); o.hex1 = seg(m_pops % DEPTH);
    return o;
  endfunction

  function automatic void chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got ledr=%h f=%b e=%b o=%b p=%b h0=%h h1=%h want ledr=%h f=%b e=%b o=%b p=%b h0=%h h1=%h",
               name, act.ledr, act.full, act.empty, act.ovf, act.playing, act.hex0, act.hex1,
               exp.ledr, exp.full, exp.empty, exp.ovf, exp.playing, exp.hex0, exp.hex1);
    end
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.ledr = ledr; o.full = full; o.empty = empty; o.ovf = ovf; o.playing = playing;
    o.hex0 = hex0; o.hex1 = hex1;
    return o;
  endfunction

  // Monitor: every settled cycle has one expected snapshot queued by the driver.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() != 0) chk("cycle", dut_obs(), exp_q.pop_front());
  end

  task automatic step(input bit w, input bit r, input bit p, input logic [9:0] d);
    @(negedge clk);
    wr = w; rd = r; pl = p; sw = d;
    model_step(w, r, p, d);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    wr = 0; rd = 0; pl = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic do_reset(input string name);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk(name, dut_obs(), model_obs());
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    chk("reset_init", dut_obs(), model_obs());
    @(negedge clk);
    rst = 1'b0;

    // two words in, two out
    step(1, 0, 0, 10'h155); step(1, 0, 0, 10'h2AA);
    step(0, 1, 0, '0); step(0, 1, 0, '0); step(0, 1, 0, '0);

    // fill, overflow, drain
    for (int i = 1; i <= 9; i++) step(1, 0, 0, 10'(i));
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0);

    // timed playback to empty
    for (int i = 0; i < 3; i++) step(1, 0, 0, 10'(16 + i));
    step(0, 0, 1, '0); idle(14);

    // abort after second pop, then manual read
    for (int i = 0; i < 5; i++) step(1, 0, 0, 10'(32 + i));
    step(0, 0, 1, '0); idle(8);
    step(0, 0, 1, '0); idle(2); step(0, 1, 0, '0); step(0, 1, 0, '0); idle(2);
    step(0, 1, 0, '0); step(0, 1, 0, '0); idle(1);

    // simultaneous read/write at full and at empty
    do_reset("reset_clear_ovf");
    for (int i = 0; i < 8; i++) step(1, 0, 0, 10'(64 + i));
    step(1, 1, 0, 10'h3C3); step(1, 1, 0, 10'h3C4);
    for (int i = 0; i < 8; i++) step(0, 1, 0, '0);
    step(1, 1, 0, 10'h0F0); step(0, 1, 0, '0);

    // pointer wrap
    for (int i = 0; i < 12; i++) begin step(1, 0, 0, 10'(100 + i)); step(0, 1, 0, '0); end

    // reset during playback
    for (int i = 0; i < 3; i++) step(1, 0, 0, 10'(200 + i));
    step(0, 0, 1, '0); idle(5);
    do_reset("reset_mid_play");
    idle(6);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 40, $urandom_range(99) < 30, $urandom_range(99) < 5,
           10'($urandom));
    idle(2);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
